// File: rtl/gates_checker.sv
// ---------------------------------------------------------------------------
// gates_checker
//
// Stimulus-and-check engine for the two-input, six-output logic-gate block.
// After a start request it steps {a,b} through 00, 01, 10, 11. Each vector
// is held for SETTLE_CYCLES clocks and then z is sampled for one cycle. Each
// sample is compared against the gate truth table. The engine reports an
// accumulated per-output failure mask, the first failing vector and an
// overall pass flag.
//
// Parameters:
//   SETTLE_CYCLES  clocks each vector is held before z is sampled (1..15)
//   CNT_W          settle counter width; must hold SETTLE_CYCLES-1
//
// Ports:
//   clk               system clock, rising edge
//   clr               synchronous active-high reset
//   start             run request, sampled only while idle
//   z[5:0]            response from the gate block
//   a, b              stimulus bits to the gate block (vector bits 1 and 0)
//   busy              high from the cycle after start is accepted until the
//                     done cycle is left
//   done              one-cycle pulse at the end of a run
//   pass              last completed run had no mismatches
//   fail_mask[5:0]    OR-accumulated mismatch bits, one per z output
//   first_fail_vec    {a,b} index of the first vector with any mismatch
//   first_fail_valid  first_fail_vec holds a captured value
// ---------------------------------------------------------------------------
module gates_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [5:0] z,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       mismatch;

  // Expected z for vector {a,b}:
  //   z5=AND, z4=NAND, z3=OR, z2=NOR, z1=NAND (De Morgan), z0=AND (De Morgan)
  function automatic logic [5:0] expected_z(input logic [1:0] v);
    // NOTE: a case with a default assigns the result on every path, so the
    // function maps to pure combinational logic with no stored value.
    case (v)
      2'b00:   expected_z = 6'b010110;
      2'b01:   expected_z = 6'b011010;
      2'b10:   expected_z = 6'b011010;
      default: expected_z = 6'b101001;
    endcase
  endfunction

  // Only used in SAMPLE; differences seen during SETTLE never reach state.
  assign mismatch = z ^ expected_z(vec);

  // NOTE: every register here uses non-blocking assignments so that all
  // right-hand sides see pre-edge values. For example, the pass decision
  // in SAMPLE combines the old fail_mask with this cycle's mismatch.
  always_ff @(posedge clk) begin
    // NOTE: clr is sampled on the clock edge, not asynchronously, and it
    // takes priority over every state action, including a simultaneous start.
    if (clr) begin
      state            <= IDLE;
      vec              <= 2'd0;
      cnt              <= '0;
      a                <= 1'b0;
      b                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_mask        <= 6'd0;
      first_fail_vec   <= 2'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          // Results of the previous run stay visible until a new run starts.
          if (start) begin
            vec              <= 2'd0;
            cnt              <= '0;
            fail_mask        <= 6'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            state            <= SETTLE;
          end
        end

        SETTLE: begin
          {a, b} <= vec;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          fail_mask <= fail_mask | mismatch;
          if ((mismatch != 6'd0) && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (vec == 2'd3) begin
            // The final mask is not registered yet, so fold in this sample.
            pass  <= ((fail_mask | mismatch) == 6'd0);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Drive the next vector immediately so the full settle window
            // sees the new stimulus.
            vec    <= vec + 2'd1;
            {a, b} <= vec + 2'd1;
            cnt    <= '0;
            state  <= SETTLE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          a     <= 1'b0;
          b     <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
